// File: rtl/bcd_chain_counter_if.sv
// Handshake bundle for bcd_chain_counter: count controls in, BCD digits and wrap pulses out.
interface bcd_chain_counter_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   out_to_disp;
  logic [DIGITS-1:0]     digit_carry;
  logic                  end_count;

  modport master (
    output en, up, load, load_val,
    input  out_to_disp, digit_carry, end_count
  );

  modport slave (
    input  en, up, load, load_val,
    output out_to_disp, digit_carry, end_count
  );
endinterface

// File: rtl/bcd_chain_counter.sv
// Cascaded BCD up/down counter with sanitising parallel load and a configurable top-digit modulus.
// Define BCD_CHAIN_SATURATE_EN to make the counter stop at its ends instead of wrapping.
module bcd_chain_counter #(
  parameter int DIGITS  = 2,
  parameter int TOP_MOD = 10
) (
  input logic                clk,
  input logic                reset,
  bcd_chain_counter_if.slave bus
);
  localparam logic [3:0] TopMax = 4'(TOP_MOD - 1);

  logic [DIGITS-1:0][3:0] count_q, count_d;
  logic [DIGITS-1:0]      carry_q, carry_d;
  logic                   endCount_q, endCount_d;
  logic [DIGITS-1:0]      atEdge;
  logic                   allAtEdge;
  logic                   blocked;

  function automatic logic [3:0] digitMax(input int idx);
    return (idx == DIGITS - 1) ? TopMax : 4'd9;
  endfunction

  // A digit steps when every lower digit sits at its wrap point; the whole chain settles in one cycle.
  always_comb begin
    logic chain;
    count_d    = count_q;
    carry_d    = '0;
    endCount_d = 1'b0;
    atEdge     = '0;
    allAtEdge  = 1'b0;
    blocked    = 1'b0;
    chain      = 1'b1;
    if (bus.load) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (bus.load_val[4*i +: 4] > digitMax(i)) begin
          count_d[i] = 4'd0;
        end else begin
          count_d[i] = bus.load_val[4*i +: 4];
        end
      end
    end else if (bus.en) begin
      for (int i = 0; i < DIGITS; i++) begin
        atEdge[i] = bus.up ? (count_q[i] == digitMax(i)) : (count_q[i] == 4'd0);
        chain     = chain & atEdge[i];
      end
      allAtEdge = chain;
`ifdef BCD_CHAIN_SATURATE_EN
      blocked = allAtEdge;
`endif
      chain = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (chain && !blocked) begin
          if (atEdge[i]) begin
            count_d[i] = bus.up ? 4'd0 : digitMax(i);
            carry_d[i] = 1'b1;
          end else begin
            count_d[i] = bus.up ? count_q[i] + 4'd1 : count_q[i] - 4'd1;
          end
        end
        chain = chain & atEdge[i];
      end
      endCount_d = allAtEdge;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      carry_q    <= '0;
      endCount_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      endCount_q <= endCount_d;
    end
  end

  assign bus.out_to_disp = count_q;
  assign bus.digit_carry = carry_q;
  assign bus.end_count   = endCount_q;
endmodule
